pll_lock_detector: RTL and testbench

Lock detector for the ideal PLL benchmark. Measures the period of the reference clock in cycles of input_clk_digital, the same fast clock that feeds the feedback frequency divider. Compares each period against the expected ratio and reports lock with hysteresis. It sits beside the phase detector and gives the testbench and controller a digital lock indication.

---
 rtl/pll_pkg.sv | 13 +
 rtl/pll_lock_detector_edge_sync.sv | 29 ++
 rtl/pll_lock_detector.sv | 149 ++++++++++++++
 tb/tb_pll_lock_detector.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// Shared types and default constants for the PLL lock detector.
package pll_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED
  } lock_state_t;

  localparam int unsigned DEFAULT_TOLERANCE = 1;
  localparam int unsigned DEFAULT_TIMEOUT   = 1024;

endpackage

// File: rtl/pll_lock_detector_edge_sync.sv
// Two-flop synchronizer for an asynchronous level plus a one-cycle rising-edge pulse.
// A third flop holds the previous synchronized value for edge detection.
module edge_sync_detector (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic sync3;

  // Synchronizer chain and edge-history flop
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;

endmodule

// File: rtl/pll_lock_detector.sv
// PLL lock detector: measures the reference period in fast-clock cycles,
// classifies each period against the expected ratio and reports lock with
// hysteresis, plus loss-of-reference detection.
module pll_lock_detector
  import pll_pkg::*;
#(
  parameter int unsigned EXPECTED_COUNT = 4,
  parameter int unsigned TOLERANCE      = DEFAULT_TOLERANCE,
  parameter int unsigned LOCK_CYCLES    = 8,
  parameter int unsigned UNLOCK_CYCLES  = 2,
  parameter int unsigned TIMEOUT        = DEFAULT_TIMEOUT,
  parameter int unsigned COUNT_WIDTH    = 32
) (
  input  logic                   input_clk_digital,
  input  logic                   reset,
  input  logic                   ref_clk_digital,
  output logic [COUNT_WIDTH-1:0] measured_period,
  output logic                   period_valid,
  output logic                   locked,
  output logic                   lock_lost,
  output logic                   timeout_err
);

  localparam int unsigned GOOD_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int unsigned BAD_W  = (UNLOCK_CYCLES > 1) ? $clog2(UNLOCK_CYCLES) : 1;

  localparam logic [COUNT_WIDTH-1:0] EXP_C = COUNT_WIDTH'(EXPECTED_COUNT);
  localparam logic [COUNT_WIDTH-1:0] TOL_C = COUNT_WIDTH'(TOLERANCE);
  localparam logic [COUNT_WIDTH-1:0] TMO_C = COUNT_WIDTH'(TIMEOUT);

  // Counters hold 0..N-1; reaching the last value on a further event is the trigger.
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CYCLES - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_CYCLES - 1);

  lock_state_t            state;
  logic [COUNT_WIDTH-1:0] cnt;
  logic [COUNT_WIDTH-1:0] deviation;
  logic [GOOD_W-1:0]      good_cnt;
  logic [BAD_W-1:0]       bad_cnt;
  logic                   ref_rise;
  logic                   period_good;
  logic                   timed_out;

  edge_sync_detector u_sync (
    .clk   (input_clk_digital),
    .reset (reset),
    .din   (ref_clk_digital),
    .rise  (ref_rise)
  );

  // Period counter: restarts at 1 on each reference edge, saturates at TIMEOUT
  always_ff @(posedge input_clk_digital) begin
    if (reset) begin
      cnt <= '0;
    end else if (ref_rise) begin
      cnt <= COUNT_WIDTH'(1);
    end else if (cnt < TMO_C) begin
      cnt <= cnt + COUNT_WIDTH'(1);
    end
  end

  // Unsigned absolute deviation of the current count from the expected period
  always_comb begin
    deviation   = (cnt >= EXP_C) ? (cnt - EXP_C) : (EXP_C - cnt);
    period_good = (deviation <= TOL_C);
  end

  // An edge arriving on the saturation cycle takes precedence over the timeout
  assign timed_out = (cnt == TMO_C) && !ref_rise;

  // Lock FSM with registered status outputs and pulses
  always_ff @(posedge input_clk_digital) begin
    if (reset) begin
      state           <= IDLE;
      good_cnt        <= '0;
      bad_cnt         <= '0;
      measured_period <= '0;
      period_valid    <= 1'b0;
      locked          <= 1'b0;
      lock_lost       <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      lock_lost    <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        IDLE: begin
          // First edge only starts a period; nothing is published
          if (ref_rise) begin
            state    <= ACQUIRE;
            good_cnt <= '0;
            bad_cnt  <= '0;
          end
        end
        ACQUIRE: begin
          if (ref_rise) begin
            measured_period <= cnt;
            period_valid    <= 1'b1;
            if (period_good) begin
              if (good_cnt == GOOD_LAST) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                good_cnt <= '0;
                bad_cnt  <= '0;
              end else begin
                good_cnt <= good_cnt + GOOD_W'(1);
              end
            end else begin
              good_cnt <= '0;
            end
          end else if (timed_out) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            good_cnt    <= '0;
            bad_cnt     <= '0;
          end
        end
        LOCKED: begin
          if (ref_rise) begin
            measured_period <= cnt;
            period_valid    <= 1'b1;
            if (period_good) begin
              bad_cnt <= '0;
            end else if (bad_cnt == BAD_LAST) begin
              state     <= ACQUIRE;
              locked    <= 1'b0;
              lock_lost <= 1'b1;
              good_cnt  <= '0;
              bad_cnt   <= '0;
            end else begin
              bad_cnt <= bad_cnt + BAD_W'(1);
            end
          end else if (timed_out) begin
            timeout_err <= 1'b1;
            lock_lost   <= 1'b1;
            locked      <= 1'b0;
            state       <= IDLE;
            good_cnt    <= '0;
            bad_cnt     <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_detector.sv
// Directed bench for pll_lock_detector: default instance plus a TIMEOUT=16 instance.
module tb_pll_lock_detector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ref_clk = 1'b0;

  logic [31:0] measured_period;
  logic        period_valid;
  logic        locked;
  logic        lock_lost;
  logic        timeout_err;

  logic [31:0] t_measured_period;
  logic        t_period_valid;
  logic        t_locked;
  logic        t_lock_lost;
  logic        t_timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Event log filled at every negedge sample
  int          cyc;
  int          pv_seen;
  int          mp_at[32];
  int          locked_at[32];
  int          ll_at[32];
  int          pv_cyc[32];
  int          ll_cnt;
  int          ll_cyc;
  int          to_cnt;
  int          to_cyc;
  int          t_pv_seen;
  int          t_mp_last;
  int          t_pv_cyc;
  int          t_to_cnt;
  int          t_to_cyc;

  pll_lock_detector dut (
    .input_clk_digital (clk),
    .reset             (reset),
    .ref_clk_digital   (ref_clk),
    .measured_period   (measured_period),
    .period_valid      (period_valid),
    .locked            (locked),
    .lock_lost         (lock_lost),
    .timeout_err       (timeout_err)
  );

  pll_lock_detector #(.TIMEOUT(16)) dut_t (
    .input_clk_digital (clk),
    .reset             (reset),
    .ref_clk_digital   (ref_clk),
    .measured_period   (t_measured_period),
    .period_valid      (t_period_valid),
    .locked            (t_locked),
    .lock_lost         (t_lock_lost),
    .timeout_err       (t_timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    pv_seen = 0; ll_cnt = 0; ll_cyc = -1; to_cnt = 0; to_cyc = -1;
    t_pv_seen = 0; t_mp_last = -1; t_pv_cyc = -1; t_to_cnt = 0; t_to_cyc = -1;
    for (int i = 0; i < 32; i++) begin
      mp_at[i] = -1; locked_at[i] = -1; ll_at[i] = -1; pv_cyc[i] = -1;
    end
  endtask

  // Sample outputs at the negedge, then drive the reference level for the next cycle
  task automatic cycle(input logic r);
    @(negedge clk);
    cyc++;
    if (period_valid === 1'b1) begin
      pv_seen++;
      if (pv_seen < 32) begin
        mp_at[pv_seen]     = int'(measured_period);
        locked_at[pv_seen] = int'(locked);
        ll_at[pv_seen]     = int'(lock_lost);
        pv_cyc[pv_seen]    = cyc;
      end
    end
    if (lock_lost === 1'b1) begin ll_cnt++; ll_cyc = cyc; end
    if (timeout_err === 1'b1) begin to_cnt++; to_cyc = cyc; end
    if (t_period_valid === 1'b1) begin
      t_pv_seen++; t_mp_last = int'(t_measured_period); t_pv_cyc = cyc;
    end
    if (t_timeout_err === 1'b1) begin t_to_cnt++; t_to_cyc = cyc; end
    ref_clk = r;
  endtask

  // One reference period of p cycles, high for the first half
  task automatic period(input int p);
    for (int i = 0; i < p; i++) cycle(i < p / 2);
  endtask

  task automatic periods(input int p, input int n);
    for (int k = 0; k < n; k++) period(p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ref_clk = 1'b0;
    idle(2);
    reset = 1'b0;
    clear_log();
  endtask

  initial begin
    cyc = 0;
    clear_log();

    // Reset state
    do_reset();
    check("rst_period_valid", period_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_lock_lost", lock_lost, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_measured_period", measured_period, 0);

    // Steady period 4: 12 edges, first discarded -> 11 measurements, lock on the 8th
    periods(4, 12);
    idle(4);
    check("steady_pv_count", pv_seen, 11);
    check("steady_mp1", mp_at[1], 4);
    check("steady_mp9", mp_at[9], 4);
    check("steady_spacing", pv_cyc[3] - pv_cyc[2], 4);
    check("steady_unlocked_at_7", locked_at[7], 0);
    check("steady_locked_at_8", locked_at[8], 1);
    check("steady_locked_now", locked, 1);

    // Hysteresis: one bad period keeps lock, two consecutive drop it
    do_reset();
    periods(4, 9);
    period(7);
    periods(4, 2);
    periods(7, 2);
    period(4);
    idle(4);
    check("hyst_pv_count", pv_seen, 14);
    check("hyst_mp10", mp_at[10], 7);
    check("hyst_locked_after_single_bad", locked_at[10], 1);
    check("hyst_locked_at_12", locked_at[12], 1);
    check("hyst_no_ll_at_13", ll_at[13], 0);
    check("hyst_locked_at_13", locked_at[13], 1);
    check("hyst_ll_at_14", ll_at[14], 1);
    check("hyst_unlocked_at_14", locked_at[14], 0);
    check("hyst_ll_pulse_count", ll_cnt, 1);

    // Period 5 is within tolerance
    do_reset();
    period(4);
    for (int k = 0; k < 4; k++) begin period(5); period(4); end
    period(4);
    idle(4);
    check("tol_mp2", mp_at[2], 5);
    check("tol_unlocked_at_7", locked_at[7], 0);
    check("tol_locked_at_8", locked_at[8], 1);

    // Period 6 in acquisition restarts the good count
    do_reset();
    periods(4, 3);
    period(6);
    periods(4, 9);
    idle(4);
    check("bad6_mp4", mp_at[4], 6);
    check("bad6_unlocked_at_8", locked_at[8], 0);
    check("bad6_unlocked_at_11", locked_at[11], 0);
    check("bad6_locked_at_12", locked_at[12], 1);

    // Loss of reference while locked
    do_reset();
    periods(4, 9);
    idle(1200);
    check("to_locked_before", locked_at[8], 1);
    check("to_pulse_count", to_cnt, 1);
    check("to_delay", to_cyc - pv_cyc[8], 1024);
    check("to_ll_same_cycle", ll_cyc, to_cyc);
    check("to_ll_count", ll_cnt, 1);
    check("to_unlocked", locked, 0);
    check("to_mp_held", measured_period, 4);
    period(4);
    idle(4);
    check("to_first_edge_no_pv", pv_seen, 8);
    check("to_no_repeat", to_cnt, 1);

    // Reset while locked
    do_reset();
    periods(4, 9);
    check("rl_locked_before", locked, 1);
    reset = 1'b1;
    cycle(1'b0);
    reset = 1'b0;
    check("rl_locked", locked, 0);
    check("rl_lock_lost", lock_lost, 0);
    check("rl_mp", measured_period, 0);
    cycle(1'b0);
    check("rl_lock_lost_after", lock_lost, 0);
    check("rl_ll_count", ll_cnt, 0);
    clear_log();
    periods(4, 9);
    idle(4);
    check("rl_reacq_pv_count", pv_seen, 8);
    check("rl_reacq_unlocked_at_7", locked_at[7], 0);
    check("rl_reacq_locked_at_8", locked_at[8], 1);

    // TIMEOUT=16 instance: edges exactly at cnt=16 are measured; 17 times out
    do_reset();
    periods(16, 4);
    period(17);
    period(4);
    idle(4);
    check("t16_pv_count", t_pv_seen, 4);
    check("t16_mp", t_mp_last, 16);
    check("t16_to_count", t_to_cnt, 1);
    check("t16_to_delay", t_to_cyc - t_pv_cyc, 16);
    check("t16_never_locked", t_locked, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
